hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core. Generates stall/flush enables for the IF/ID, ID/EX and EX/MEM registers and operand forwarding selects for the execute stage. Maintains its own shadow pipeline of register indices and write flags for E/M/W, advanced under the same stall/flush rules it issues. Also counts stall and flush cycles for performance monitoring.

---
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: stall/flush enables, operand
// forwarding selects and stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter logic [1:0]  LOAD_SRC  = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic [4:0]           rd_d,
    input  logic                 reg_write_d,
    input  logic [1:0]           result_src_d,
    input  logic                 pc_src_e,
    input  logic                 mem_busy_m,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 stall_e,
    output logic                 flush_e,
    output logic                 stall_m,
    output logic [1:0]           forward_a_e,
    output logic [1:0]           forward_b_e,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    logic [4:0] e_rs1, e_rs2, e_rd, m_rd, w_rd;
    logic       e_wr, e_ld, m_wr, w_wr;
    logic       ld_d, lu, busy, redirect, lu_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] x, input logic mw,
                                           input logic [4:0] mrd, input logic ww,
                                           input logic [4:0] wrd);
        if (mw && mrd != 5'd0 && mrd == x) return 2'b10;
        if (ww && wrd != 5'd0 && wrd == x) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        ld_d = (result_src_d == LOAD_SRC);
        lu   = e_ld & e_wr & (e_rd != 5'd0) & ((e_rd == rs1_d) | (e_rd == rs2_d));
        // Outputs are forced low while reset is held, whatever the inputs do.
        busy     = mem_busy_m & ~rst;
        redirect = pc_src_e & ~mem_busy_m & ~rst;
        lu_stall = lu & ~pc_src_e & ~mem_busy_m & ~rst;

        stall_f = busy | lu_stall;
        stall_d = busy | lu_stall;
        stall_e = busy;
        stall_m = busy;
        flush_d = redirect;
        flush_e = redirect | lu_stall;

        forward_a_e = fwd_sel(e_rs1, m_wr, m_rd, w_wr, w_rd);
        forward_b_e = fwd_sel(e_rs2, m_wr, m_rd, w_wr, w_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_rs1     <= '0;
            e_rs2     <= '0;
            e_rd      <= '0;
            e_wr      <= 1'b0;
            e_ld      <= 1'b0;
            m_rd      <= '0;
            m_wr      <= 1'b0;
            w_rd      <= '0;
            w_wr      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mem_busy_m) begin
                // E and M hold; W receives a bubble.
                w_wr <= 1'b0;
            end else begin
                m_rd <= e_rd;
                m_wr <= e_wr;
                w_rd <= m_rd;
                w_wr <= m_wr;
                if (pc_src_e || lu) begin
                    e_rs1 <= '0;
                    e_rs2 <= '0;
                    e_rd  <= '0;
                    e_wr  <= 1'b0;
                    e_ld  <= 1'b0;
                end else begin
                    e_rs1 <= rs1_d;
                    e_rs2 <= rs2_d;
                    e_rd  <= rd_d;
                    e_wr  <= reg_write_d;
                    e_ld  <= ld_d;
                end
            end
            if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if (flush_e && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with hand-computed expectations per scenario.
module tb_hazard_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   rs1_d, rs2_d, rd_d;
    logic         reg_write_d;
    logic [1:0]   result_src_d;
    logic         pc_src_e, mem_busy_m;
    logic         stall_f, stall_d, flush_d, stall_e, flush_e, stall_m;
    logic [1:0]   forward_a_e, forward_b_e;
    logic [W-1:0] stall_cnt, flush_cnt;
    logic [5:0]   ctl;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.CNT_WIDTH(W), .LOAD_SRC(2'b01)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .result_src_d(result_src_d),
        .pc_src_e(pc_src_e), .mem_busy_m(mem_busy_m),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .stall_e(stall_e), .flush_e(flush_e), .stall_m(stall_m),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

    task automatic drive_d(input logic [4:0] a, input logic [4:0] b, input logic [4:0] rd,
                           input logic wr, input logic [1:0] src);
        rs1_d = a; rs2_d = b; rd_d = rd; reg_write_d = wr; result_src_d = src;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_src_e = 1'b1; mem_busy_m = 1'b1;
        drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        #12;
        total++;
        if (ctl !== 6'b000000) begin
            bad++; $display("FAIL reset_ctl: got %b want %b", ctl, 6'b000000);
        end
        total++;
        if ({forward_a_e, forward_b_e} !== 4'b0000) begin
            bad++; $display("FAIL reset_fwd: got %b want %b", {forward_a_e, forward_b_e}, 4'b0);
        end
        total++;
        if ({stall_cnt, flush_cnt} !== 8'h00) begin
            bad++; $display("FAIL reset_cnt: got %h want %h", {stall_cnt, flush_cnt}, 8'h00);
        end
        pc_src_e = 1'b0; mem_busy_m = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back();
        drive_d(5'd1, 5'd0, 5'd5, 1'b1, 2'b00);      // addi x5, x1
        tick();
        drive_d(5'd5, 5'd1, 5'd6, 1'b1, 2'b00);      // add x6, x5, x1
        tick();
        total++;
        if (forward_a_e !== 2'b10) begin
            bad++; $display("FAIL b2b_fwd_a_m: got %b want %b", forward_a_e, 2'b10);
        end
        total++;
        if (forward_b_e !== 2'b00) begin
            bad++; $display("FAIL b2b_fwd_b_none: got %b want %b", forward_b_e, 2'b00);
        end
        total++;
        if (ctl !== 6'b000000) begin
            bad++; $display("FAIL b2b_no_stall: got %b want %b", ctl, 6'b0);
        end
        drive_d(5'd1, 5'd0, 5'd5, 1'b1, 2'b00);      // addi x5
        tick();
        drive_d(5'd2, 5'd3, 5'd8, 1'b1, 2'b00);      // independent, writes x8
        tick();
        drive_d(5'd5, 5'd8, 5'd9, 1'b1, 2'b00);      // consumes x5 (W) and x8 (M)
        tick();
        total++;
        if ({forward_a_e, forward_b_e} !== 4'b0110) begin
            bad++; $display("FAIL gap_fwd: got %b want %b", {forward_a_e, forward_b_e}, 4'b0110);
        end
        drive_d(5'd0, 5'd0, 5'd10, 1'b1, 2'b00);
        tick();
        drive_d(5'd0, 5'd0, 5'd10, 1'b1, 2'b00);
        tick();
        drive_d(5'd10, 5'd0, 5'd11, 1'b1, 2'b00);    // x10 in both M and W: M wins
        tick();
        total++;
        if (forward_a_e !== 2'b10) begin
            bad++; $display("FAIL m_over_w: got %b want %b", forward_a_e, 2'b10);
        end
    endtask

    task automatic test_load_use();
        drive_d(5'd2, 5'd0, 5'd7, 1'b1, 2'b01);      // lw x7
        tick();
        drive_d(5'd3, 5'd7, 5'd11, 1'b1, 2'b00);     // uses x7 as rs2
        #1;
        total++;
        if (ctl !== 6'b110001) begin
            bad++; $display("FAIL lu_ctl: got %b want %b", ctl, 6'b110001);
        end
        tick();
        total++;
        if (ctl !== 6'b000000) begin
            bad++; $display("FAIL lu_clears: got %b want %b", ctl, 6'b0);
        end
        tick();
        total++;
        if (forward_b_e !== 2'b01) begin
            bad++; $display("FAIL lu_fwd_b: got %b want %b", forward_b_e, 2'b01);
        end
        total++;
        if ({stall_cnt, flush_cnt} !== {4'd1, 4'd1}) begin
            bad++; $display("FAIL lu_cnt: got %h want %h", {stall_cnt, flush_cnt}, 8'h11);
        end
    endtask

    task automatic test_load_x0();
        drive_d(5'd2, 5'd0, 5'd0, 1'b1, 2'b01);      // lw x0
        tick();
        drive_d(5'd0, 5'd0, 5'd12, 1'b1, 2'b00);
        #1;
        total++;
        if (ctl !== 6'b000000) begin
            bad++; $display("FAIL x0_no_stall: got %b want %b", ctl, 6'b0);
        end
        tick();
        total++;
        if ({forward_a_e, forward_b_e} !== 4'b0000) begin
            bad++; $display("FAIL x0_fwd: got %b want %b", {forward_a_e, forward_b_e}, 4'b0);
        end
    endtask

    task automatic test_branch_over_lu();
        drive_d(5'd2, 5'd0, 5'd7, 1'b1, 2'b01);      // lw x7
        tick();
        drive_d(5'd7, 5'd0, 5'd13, 1'b1, 2'b00);
        pc_src_e = 1'b1;
        #1;
        total++;
        if (ctl !== 6'b000011) begin
            bad++; $display("FAIL br_lu_ctl: got %b want %b", ctl, 6'b000011);
        end
        tick();
        pc_src_e = 1'b0;
        #1;
        total++;
        if ({stall_cnt, flush_cnt} !== {4'd1, 4'd2}) begin
            bad++; $display("FAIL br_lu_cnt: got %h want %h", {stall_cnt, flush_cnt}, 8'h12);
        end
    endtask

    task automatic test_mem_busy();
        drive_d(5'd0, 5'd0, 5'd12, 1'b1, 2'b00);     // A writes x12
        tick();
        drive_d(5'd0, 5'd0, 5'd13, 1'b1, 2'b00);     // B writes x13
        tick();
        drive_d(5'd12, 5'd13, 5'd0, 1'b0, 2'b00);    // branch reading x12, x13
        tick();
        drive_d(5'd1, 5'd2, 5'd14, 1'b1, 2'b00);
        pc_src_e = 1'b1; mem_busy_m = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (ctl !== 6'b111100) begin
                bad++; $display("FAIL busy_ctl_c%0d: got %b want %b", c, ctl, 6'b111100);
            end
            // W gets a bubble after the first busy edge, so x12 stops forwarding.
            total++;
            if ({forward_a_e, forward_b_e} !== ((c == 0) ? 4'b0110 : 4'b0010)) begin
                bad++; $display("FAIL busy_fwd_c%0d: got %b want %b", c,
                                {forward_a_e, forward_b_e}, (c == 0) ? 4'b0110 : 4'b0010);
            end
            tick();
        end
        mem_busy_m = 1'b0;
        #1;
        total++;
        if (ctl !== 6'b000011) begin
            bad++; $display("FAIL busy_then_flush: got %b want %b", ctl, 6'b000011);
        end
        tick();
        pc_src_e = 1'b0;
        #1;
        total++;
        if ({stall_cnt, flush_cnt} !== {4'd4, 4'd3}) begin
            bad++; $display("FAIL busy_cnt: got %h want %h", {stall_cnt, flush_cnt}, 8'h43);
        end
    endtask

    task automatic test_saturation_and_reset();
        mem_busy_m = 1'b1;
        repeat (20) tick();
        total++;
        if (stall_cnt !== 4'hf) begin
            bad++; $display("FAIL sat_stall_cnt: got %h want %h", stall_cnt, 4'hf);
        end
        total++;
        if (flush_cnt !== 4'd3) begin
            bad++; $display("FAIL sat_flush_cnt: got %h want %h", flush_cnt, 4'd3);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (ctl !== 6'b000000) begin
            bad++; $display("FAIL midstall_rst_ctl: got %b want %b", ctl, 6'b0);
        end
        total++;
        if ({stall_cnt, flush_cnt, forward_a_e, forward_b_e} !== 12'h000) begin
            bad++; $display("FAIL midstall_rst_state: got %h want %h",
                            {stall_cnt, flush_cnt, forward_a_e, forward_b_e}, 12'h000);
        end
        mem_busy_m = 1'b0;
        tick();
        rst = 1'b0;
        drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        tick();
        total++;
        if ({ctl, stall_cnt, flush_cnt} !== 14'h0) begin
            bad++; $display("FAIL post_rst_idle: got %h want %h", {ctl, stall_cnt, flush_cnt}, 14'h0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_load_x0();
        test_branch_over_lu();
        test_mem_busy();
        test_saturation_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
